// File: rtl/gf2_linear_solver_if.sv
// Request/result bundle for gf2_linear_solver: matrix and right-hand side in,
// busy/done status and the recovered vector out.
interface gf2_linear_solver_if #(
    parameter int N = 3
);
    // Handshake: start is accepted on a rising edge only while busy=0. There is
    // no backpressure and no queueing. done is a one-cycle pulse, and v,
    // singular and check_err then stay valid until the next accepted start.
    logic             start;
    logic [N*N-1:0]   m;
    logic [N-1:0]     u;
    logic             busy;
    logic             done;
    logic             singular;
    logic [N-1:0]     v;
    logic             check_err;

    modport master (
        output start, m, u,
        input  busy, done, singular, v, check_err
    );

    modport slave (
        input  start, m, u,
        output busy, done, singular, v, check_err
    );
endinterface

// File: rtl/gf2_linear_solver.sv
// Gauss-Jordan solver for M*v = u over GF(2) on an N x (N+1) augmented matrix.
// Defining GF2_SOLVER_VERIFY_EN adds a one-cycle M*v == u self-check before done.
module gf2_linear_solver #(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    gf2_linear_solver_if.slave bus,
    output logic [2:0]         dbg_state
);
    localparam int W = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_SWAP   = 3'd2,
        S_ELIM   = 3'd3,
        S_DONE   = 3'd4
`ifdef GF2_SOLVER_VERIFY_EN
        , S_CHECK = 3'd5
`endif
    } state_t;

    state_t       state, state_n;
    // Row i holds {u[i], M[i][N-1:0]}; bit j < N is column j, bit N is the RHS.
    logic [N:0]   a   [N];
    logic [N:0]   a_n [N];
    logic [W-1:0] c, c_n;
    logic [W-1:0] r, r_n;
    logic [W-1:0] p, p_n;
    logic         singular_q, singular_n;
    logic [N-1:0] v_q, v_n;
    logic [N:0]   row_c, row_p, row_r;

`ifdef GF2_SOLVER_VERIFY_EN
    logic [N*N-1:0] m_cap, m_cap_n;
    logic [N-1:0]   u_cap, u_cap_n;
    logic [N-1:0]   prod;
    logic           check_err_q, check_err_n;
`endif

    function automatic logic col_bit(input logic [N:0] row, input logic [W-1:0] col);
        logic b;
        b = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (W'(j) == col) b = row[j];
        end
        return b;
    endfunction

    always_comb begin
        row_c = '0;
        row_p = '0;
        row_r = '0;
        for (int i = 0; i < N; i++) begin
            if (W'(i) == c) row_c = a[i];
            if (W'(i) == p) row_p = a[i];
            if (W'(i) == r) row_r = a[i];
        end
    end

    always_comb begin
        state_n    = state;
        a_n        = a;
        c_n        = c;
        r_n        = r;
        p_n        = p;
        singular_n = singular_q;
        v_n        = v_q;
`ifdef GF2_SOLVER_VERIFY_EN
        m_cap_n     = m_cap;
        u_cap_n     = u_cap;
        check_err_n = check_err_q;
        prod        = '0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    for (int i = 0; i < N; i++) begin
                        a_n[i] = {bus.u[i], bus.m[i*N +: N]};
                    end
                    c_n        = '0;
                    r_n        = '0;
                    singular_n = 1'b0;
`ifdef GF2_SOLVER_VERIFY_EN
                    m_cap_n     = bus.m;
                    u_cap_n     = bus.u;
                    check_err_n = 1'b0;
`endif
                    state_n    = S_SEARCH;
                end else if (state == S_DONE) begin
                    state_n = S_IDLE;
                end
            end
            S_SEARCH: begin
                if (col_bit(row_r, c)) begin
                    p_n     = r;
                    state_n = S_SWAP;
                end else if (r != W'(N - 1)) begin
                    r_n = r + W'(1);
                end else begin
                    singular_n = 1'b1;
                    v_n        = '0;
                    state_n    = S_DONE;
                end
            end
            S_SWAP: begin
                // When p == c the first branch wins and the row is rewritten unchanged.
                for (int i = 0; i < N; i++) begin
                    if (W'(i) == c)      a_n[i] = row_p;
                    else if (W'(i) == p) a_n[i] = row_c;
                end
                state_n = S_ELIM;
            end
            S_ELIM: begin
                for (int i = 0; i < N; i++) begin
                    if ((W'(i) != c) && col_bit(a[i], c)) a_n[i] = a[i] ^ row_c;
                end
                c_n = c + W'(1);
                r_n = c + W'(1);
                if (c == W'(N - 1)) begin
                    // After the last column the left block is I, so the RHS column is v.
                    for (int j = 0; j < N; j++) begin
                        v_n[j] = a_n[j][N];
                    end
`ifdef GF2_SOLVER_VERIFY_EN
                    state_n = S_CHECK;
`else
                    state_n = S_DONE;
`endif
                end else begin
                    state_n = S_SEARCH;
                end
            end
`ifdef GF2_SOLVER_VERIFY_EN
            S_CHECK: begin
                for (int i = 0; i < N; i++) begin
                    prod[i] = ^(m_cap[i*N +: N] & v_q);
                end
                check_err_n = (prod != u_cap);
                state_n     = S_DONE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            singular_q <= 1'b0;
            v_q        <= '0;
`ifdef GF2_SOLVER_VERIFY_EN
            check_err_q <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            a          <= a_n;
            c          <= c_n;
            r          <= r_n;
            p          <= p_n;
            singular_q <= singular_n;
            v_q        <= v_n;
`ifdef GF2_SOLVER_VERIFY_EN
            m_cap       <= m_cap_n;
            u_cap       <= u_cap_n;
            check_err_q <= check_err_n;
`endif
        end
    end

    assign bus.busy     = (state != S_IDLE) && (state != S_DONE);
    assign bus.done     = (state == S_DONE);
    assign bus.singular = singular_q;
    assign bus.v        = v_q;
`ifdef GF2_SOLVER_VERIFY_EN
    assign bus.check_err = check_err_q;
`else
    assign bus.check_err = 1'b0;
`endif
    assign dbg_state = state;
endmodule

// File: tb/tb_gf2_linear_solver.sv
// Directed bench for gf2_linear_solver (N=3) plus a full-rank sweep on an N=4 instance
// whose matrices are products of elementary row operations.
module tb_gf2_linear_solver;
`ifdef GF2_SOLVER_VERIFY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    gf2_linear_solver_if #(.N(3)) bus3 ();
    gf2_linear_solver_if #(.N(4)) bus4 ();
    logic [2:0] dbg3;
    logic [2:0] dbg4;

    gf2_linear_solver #(.N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus3),
        .dbg_state (dbg3)
    );

    gf2_linear_solver #(.N(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4),
        .dbg_state (dbg4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start3(input logic [8:0] mm, input logic [2:0] uu);
        bus3.m = mm;
        bus3.u = uu;
        bus3.start = 1'b1;
        @(posedge clk); #1;
        bus3.start = 1'b0;
    endtask

    // Returns the cycle number (SEARCH = cycle 1) in which done is seen, -1 on timeout.
    task automatic wait3(input int pulse_at, output int lat);
        int cyc;
        cyc = 1;
        lat = -1;
        while (cyc <= 40) begin
            if (bus3.done) begin
                lat = cyc;
                break;
            end
            bus3.start = (cyc == pulse_at);
            @(posedge clk); #1;
            bus3.start = 1'b0;
            cyc++;
        end
    endtask

    task automatic start4(input logic [15:0] mm, input logic [3:0] uu);
        bus4.m = mm;
        bus4.u = uu;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
    endtask

    task automatic wait4(output int lat);
        int cyc;
        cyc = 1;
        lat = -1;
        while (cyc <= 40) begin
            if (bus4.done) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dones;
        logic [3:0]  rows [4];
        logic [3:0]  tmp;
        logic [3:0]  vv;
        logic [3:0]  uu;
        logic [15:0] mm;

        bus3.start = 1'b0; bus3.m = '0; bus3.u = '0;
        bus4.start = 1'b0; bus4.m = '0; bus4.u = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus3.busy, 0);
        check("rst_done", bus3.done, 0);
        check("rst_singular", bus3.singular, 0);
        check("rst_v", bus3.v, 0);
        check("rst_check_err", bus3.check_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity, inputs scrambled after capture
        start3(9'b100_010_001, 3'b101);
        bus3.m = 9'h1FF;
        bus3.u = 3'b010;
        check("id_busy", bus3.busy, 1);
        wait3(0, lat);
        check("id_lat", lat, 10 + EXTRA);
        check("id_v", bus3.v, 3'b101);
        check("id_singular", bus3.singular, 0);
        check("id_check_err", bus3.check_err, 0);
        @(posedge clk); #1;
        check("id_done_pulse", bus3.done, 0);
        check("id_idle_busy", bus3.busy, 0);

        // Pivot requires a row swap in column 0
        start3(9'b100_001_010, 3'b101);
        wait3(0, lat);
        check("swap_lat", lat, 11 + EXTRA);
        check("swap_v", bus3.v, 3'b110);
        check("swap_singular", bus3.singular, 0);

        // All-ones matrix: no pivot in column 1
        @(posedge clk); #1;
        start3(9'h1FF, 3'b111);
        wait3(0, lat);
        check("sing_lat", lat, 6);
        check("sing_flag", bus3.singular, 1);
        check("sing_v", bus3.v, 0);
        check("sing_check_err", bus3.check_err, 0);

        // Start while busy is ignored; then back-to-back start in the DONE cycle
        @(posedge clk); #1;
        start3(9'b100_010_001, 3'b100);
        bus3.m = 9'b000_000_000;
        bus3.u = 3'b111;
        wait3(4, lat);
        check("ign_lat", lat, 10 + EXTRA);
        check("ign_v", bus3.v, 3'b100);
        check("ign_singular", bus3.singular, 0);
        start3(9'b100_110_011, 3'b010);
        check("b2b_busy", bus3.busy, 1);
        wait3(0, lat);
        check("b2b_lat", lat, 10 + EXTRA);
        check("b2b_v", bus3.v, 3'b011);
        check("b2b_singular", bus3.singular, 0);
        check("b2b_check_err", bus3.check_err, 0);

        // Reset during the first ELIM aborts the solve
        @(posedge clk); #1;
        start3(9'b100_010_001, 3'b101);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_in_elim", dbg3, 3'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", bus3.busy, 0);
        check("abort_done", bus3.done, 0);
        check("abort_v", bus3.v, 0);
        check("abort_singular", bus3.singular, 0);
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus3.done) dones++;
        end
        check("abort_no_done", dones, 0);
        start3(9'b100_001_010, 3'b101);
        wait3(0, lat);
        check("after_abort_lat", lat, 11 + EXTRA);
        check("after_abort_v", bus3.v, 3'b110);

        // Full-rank sweep, N=4: latency bounds are 3N+1 and 1+sum(N-c+2)
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < 4; i++) rows[i] = 4'(1 << i);
            for (int s = 0; s < 12; s++) begin
                int ia;
                int ib;
                ia = $urandom_range(0, 3);
                ib = $urandom_range(0, 3);
                if (ia != ib) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rows[ia] = rows[ia] ^ rows[ib];
                    end else begin
                        tmp = rows[ia];
                        rows[ia] = rows[ib];
                        rows[ib] = tmp;
                    end
                end
            end
            vv = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                mm[i*4 +: 4] = rows[i];
                uu[i] = ^(rows[i] & vv);
            end
            start4(mm, uu);
            wait4(lat);
            check("rand_v", bus4.v, vv);
            check("rand_singular", bus4.singular, 0);
            check("rand_check_err", bus4.check_err, 0);
            check("rand_lat_bounds", (lat >= 13 + EXTRA) && (lat <= 19 + EXTRA), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
